// File: rtl/perceptron_axil_slave.sv
// AXI4-Lite register block for a 4-input perceptron: X/W/BIAS registers, a start
// strobe in CTRL, and a 4-cycle multiply-accumulate producing RESULT and y.
module perceptron_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            done_o,
  output logic                            y_o,
  output logic [1:0]                      dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  logic [31:0] x_q, w_q, bias_q, scratch_q;
  logic [31:0] xs_q, ws_q, acc_q, result_q;
  logic [1:0]  idx_q;
  logic        done_q, y_q;
  logic        wr_fire, rd_fire, start_req, start_ok;
  logic [2:0]  wr_idx, rd_idx;
  logic [7:0]  x_lane, w_lane;
  logic [15:0] prod;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Valid/ready: a transfer happens on the edge where VALID and READY are both high.
  // READY is a registered one-cycle pulse, so a master must hold VALID until it sees it;
  // BVALID/RVALID then hold (with RDATA stable) until the matching READY is sampled high.
  assign wr_fire   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire   = arready_q & S_AXI_ARVALID;
  assign wr_idx    = S_AXI_AWADDR[4:2];
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign start_req = wr_fire && (wr_idx == 3'd4) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign done_o        = done_q;
  assign y_o           = y_q;
  assign dbg_state_o   = state_q;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_mux = 32'd0;
    case (rd_idx)
      3'd0: rd_mux = x_q;
      3'd1: rd_mux = w_q;
      3'd2: rd_mux = bias_q;
      3'd3: rd_mux = scratch_q;
      3'd5: rd_mux = {29'd0, y_q, done_q, state_q != ST_IDLE};
      3'd6: rd_mux = result_q;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      x_q       <= 32'd0;
      w_q       <= 32'd0;
      bias_q    <= 32'd0;
      scratch_q <= 32'd0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_fire) begin
        case (wr_idx)
          3'd0: x_q       <= apply_strb(x_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd1: w_q       <= apply_strb(w_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd2: bias_q    <= apply_strb(bias_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd3: scratch_q <= apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Lane idx of the snapshot; product of two int8 always fits in 16 bits.
  assign x_lane = xs_q[{idx_q, 3'b000} +: 8];
  assign w_lane = ws_q[{idx_q, 3'b000} +: 8];
  assign prod   = {{8{x_lane[7]}}, x_lane} * {{8{w_lane[7]}}, w_lane};

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          start_ok = 1'b1;
          state_d  = ST_MAC;
        end
      end
      ST_MAC:    if (idx_q == 2'd3) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      xs_q     <= 32'd0;
      ws_q     <= 32'd0;
      acc_q    <= 32'd0;
      idx_q    <= 2'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        xs_q   <= x_q;
        ws_q   <= w_q;
        acc_q  <= bias_q;
        idx_q  <= 2'd0;
        done_q <= 1'b0;
      end
      if (state_q == ST_MAC) begin
        acc_q <= acc_q + {{16{prod[15]}}, prod};
        idx_q <= idx_q + 2'd1;
      end
      if (state_q == ST_FINISH) begin
        result_q <= acc_q;
        y_q      <= ~acc_q[31] & (|acc_q);
        done_q   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/perceptron_axil_slave.md
# perceptron_axil_slave

AXI4-Lite slave register block for the perceptron IP, sitting behind the `S00_AXI` port that the master VIP drives in the block-design bench. It holds four signed 8-bit inputs, four signed 8-bit weights and a 32-bit bias. A write to CTRL launches a 4-cycle multiply-accumulate. Software then reads the result and the sign-threshold output.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
- S_AXI_ACLK  in  1  single clock, rising edge.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWADDR  in  5  write address; bits [1:0] are ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  5  read address; bits [1:0] are ignored.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- done_o  out  1  mirror of STATUS.done.
- y_o  out  1  mirror of STATUS.y (perceptron output).

## Operation
- Register map (word offset):
  - 0x00 X: RW; lane i = bits [8i+7:8i], signed.
  - 0x04 W: RW; same lane layout, signed.
  - 0x08 BIAS: RW, signed 32-bit.
  - 0x0C SCRATCH: RW, no function.
  - 0x10 CTRL: write bit0=1 requests start; reads return 0.
  - 0x14 STATUS: RO; bit0 busy, bit1 done, bit2 y, others 0.
  - 0x18 RESULT: RO, signed 32-bit accumulator.
  - 0x1C: reads 0, writes ignored.
- RW registers honour WSTRB per byte.
- Writes to RO or unused offsets complete with OKAY and have no effect.
- A CTRL start counts only if WSTRB[0]=1, WDATA[0]=1 and state is IDLE. A start while busy is ignored.
- Compute FSM states: IDLE, MAC, FINISH.
- IDLE→MAC on an accepted start:
  - snapshot X, W and BIAS into shadow registers;
  - acc ← BIAS, idx ← 0, busy ← 1, done ← 0.
- In MAC, each cycle: acc ← acc + sext32(x[idx]·w[idx]).
  - Product is a 16-bit signed value, sign-extended to 32 bits.
  - acc wraps modulo 2^32.
  - idx increments each cycle; at idx=3, next state is FINISH.
- FINISH:
  - RESULT ← acc; y ← (acc > 0, signed); done ← 1; busy ← 0.
  - Next state is IDLE.
- Writes to X, W or BIAS during busy update the registers but do not affect the running computation.
- done is sticky until the next accepted start.

## Timing
- Reset values: all registers, RESULT and STATUS are 0; FSM is IDLE; every READY/VALID output is 0; RDATA=0; done_o=0; y_o=0.
- Reset asserted mid-compute aborts immediately; no done is produced.
- Write channel:
  - AWREADY and WREADY pulse high together for exactly one cycle, when AWVALID & WVALID & !BVALID & !AWREADY.
  - The register is updated on that edge.
  - BVALID rises on the next cycle and holds until BREADY.
  - At most one write is outstanding.
  - AW without W, or W without AW, waits indefinitely and stalls.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID & !ARREADY.
  - RDATA is registered, and RVALID rises on the next cycle.
  - RDATA and RVALID hold stable until RREADY.
  - Reads and writes proceed independently.
  - A read of STATUS in the start-handshake cycle returns the pre-start value.
- Compute latency: start accepted at edge T.
  - busy=1 is visible from T+1.
  - MAC runs during T+1..T+4.
  - RESULT, done and y are updated at T+5.
  - A new start is accepted from T+6.

## Test plan
- **Reset:** hold ARESETN low for 200 ns → all outputs 0. A read of any register at 0x00–0x1C returns 0.
- **Scratch readback:** AXI4-Lite write 1,2,3,4 to 0x00,0x04,0x08,0x0C → BRESP=0 each time. Reading back the same offsets returns 0x1,0x2,0x3,0x4.
- **Compute:**
  - Setup: X=0x04FD0201 (1,2,−3,4); W=0x02030405 (5,4,3,2); BIAS=0xFFFFFFF6 (−10).
  - Stimulus: write CTRL=1.
  - Expected: partial sums 5+8−9+8=12, so RESULT=0x00000002, STATUS=0x6, done_o=1, y_o=1, exactly 5 cycles after the start handshake.
- **Negative and byte-lane:**
  - Setup: X=0x80808080, W=0x7F7F7F7F, BIAS=0.
  - Expected result: RESULT=0xFFFF0200, y=0.
  - Byte-lane check: a WSTRB=4'b0001 write of 0xFFFFFFFF to SCRATCH=0 reads back 0x000000FF.
- **Busy interactions:**
  - Second CTRL write during busy → ignored; the first result is unchanged.
  - Writing W during busy → RESULT reflects the old W; W reads back the new value.
  - Reset asserted at MAC cycle 2 → STATUS=0 after reset.
- **Backpressure:**
  - BREADY held low for 10 cycles → BVALID held and no further AWREADY.
  - RREADY held low → RDATA stable.
  - AWVALID raised 3 cycles before WVALID → handshake occurs only when both are high.
